// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-cycle multiply/divide unit with HI/LO result registers.
// Multiplication is radix-2 shift-add and division is restoring shift-subtract.
// Both work on operand magnitudes, and the signs are applied in a final FIX cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_Control,
  input  logic [WIDTH-1:0] src_A,
  input  logic [WIDTH-1:0] src_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_By_Zero
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state;
  state_t state_next;

  logic       accept_op;
  logic       step_en;
  logic       fix_en;
  logic       write_hi;
  logic       write_lo;
  logic [4:0] count;

  // Latched operation context; it is captured only when an op is accepted.
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Working registers.
  // Multiply: acc is the upper product half; shreg is the multiplier, shifted out as product bits arrive.
  // Divide: acc is the partial remainder; shreg is the dividend, shifted out as quotient bits arrive.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;

  logic             op_signed;
  logic             src_a_neg;
  logic             src_b_neg;
  logic [WIDTH-1:0] src_a_mag;
  logic [WIDTH-1:0] src_b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] shreg_step;

  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   dividend_raw;
  logic               div_zero;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dbz;

  // Operand sign handling at accept time.
  // Codes 000 and 010 are the signed ops, and bit 0 clear marks them.
  always_comb begin
    op_signed = ~md_Control[0];
    src_a_neg = op_signed & src_A[WIDTH-1];
    src_b_neg = op_signed & src_B[WIDTH-1];
    src_a_mag = src_a_neg ? -src_A : src_A;
    src_b_mag = src_b_neg ? -src_B : src_B;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and control strobes; MTHI/MTLO complete in IDLE without entering RUN.
  always_comb begin
    state_next = state;
    accept_op  = 1'b0;
    step_en    = 1'b0;
    fix_en     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!md_Control[2]) begin
            accept_op  = 1'b1;
            state_next = RUN;
          end else if (md_Control == OP_MTHI) begin
            write_hi = 1'b1;
          end else if (md_Control == OP_MTLO) begin
            write_lo = 1'b1;
          end
        end
      end
      RUN: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (count == LAST_STEP) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        fix_en     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One iteration step: a conditional add then a right shift (mul), or a trial subtract then a left shift (div).
  always_comb begin
    mul_sum    = {1'b0, acc} + (shreg[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
    div_shift  = {acc, shreg[WIDTH-1]};
    div_fits   = (div_shift >= {1'b0, b_mag});
    div_diff   = div_shift[WIDTH-1:0] - b_mag;
    acc_step   = mul_sum[WIDTH:1];
    shreg_step = {mul_sum[0], shreg[WIDTH-1:1]};
    if (is_div) begin
      acc_step   = div_fits ? div_diff : div_shift[WIDTH-1:0];
      shreg_step = {shreg[WIDTH-2:0], div_fits};
    end
  end

  // Datapath registers: capture magnitudes on accept, then iterate once per RUN cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count  <= 5'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      shreg  <= '0;
    end else if (accept_op) begin
      count  <= 5'd0;
      is_div <= md_Control[1];
      neg_a  <= src_a_neg;
      neg_b  <= src_b_neg;
      a_mag  <= src_a_mag;
      b_mag  <= src_b_mag;
      acc    <= '0;
      shreg  <= md_Control[1] ? src_a_mag : src_b_mag;
    end else if (step_en) begin
      count <= count + 5'd1;
      acc   <= acc_step;
      shreg <= shreg_step;
    end
  end

  // Sign fix-up and divide-by-zero override.
  // The raw dividend is rebuilt from its magnitude, so the original src_A value need not be stored.
  always_comb begin
    product       = {acc, shreg};
    product_fixed = (neg_a ^ neg_b) ? -product : product;
    quot_fixed    = (neg_a ^ neg_b) ? -shreg : shreg;
    rem_fixed     = neg_a ? -acc : acc;
    dividend_raw  = neg_a ? -a_mag : a_mag;
    div_zero      = (b_mag == '0);
    fix_dbz       = 1'b0;
    if (!is_div) begin
      fix_hi = product_fixed[2*WIDTH-1:WIDTH];
      fix_lo = product_fixed[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi  = dividend_raw;
      fix_lo  = '1;
      fix_dbz = 1'b1;
    end else begin
      fix_hi = rem_fixed;
      fix_lo = quot_fixed;
    end
  end

  // HI/LO and status outputs.
  // They hold their values between ops, done pulses for the single FIX cycle, and div_By_Zero clears on a new accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_By_Zero <= 1'b0;
    end else begin
      done <= fix_en;
      if (accept_op) begin
        div_By_Zero <= 1'b0;
      end
      if (fix_en) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        div_By_Zero <= fix_dbz;
      end
      if (write_hi) begin
        hi <= src_A;
      end
      if (write_lo) begin
        lo <= src_A;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit.
// An arithmetic reference model is compared against the DUT every cycle.
// Results are also checked against hand-computed literal values.
module tb_mul_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  md_Control;
  logic [31:0] src_A;
  logic [31:0] src_B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_By_Zero;

  int tests    = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model state.
  bit          m_busy;
  bit          m_done;
  bit          m_dbz;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  bit          p_dbz;
  int          m_cnt;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .md_Control  (md_Control),
    .src_A       (src_A),
    .src_B       (src_B),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_By_Zero (div_By_Zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Plain-arithmetic result of one mul/div op.
  function automatic void modelOp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (code)
      3'b000: begin
        r = sa * sb;
        h = r[63:32];
        l = r[31:0];
      end
      3'b001: begin
        ur = ua * ub;
        h  = ur[63:32];
        l  = ur[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h  = a;
          l  = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (code == 3'b010) begin
          r = sa / sb;
          l = r[31:0];
          r = sa % sb;
          h = r[31:0];
        end else begin
          ur = ua / ub;
          l  = ur[31:0];
          ur = ua % ub;
          h  = ur[31:0];
        end
      end
    endcase
  endfunction

  // Model timeline: an accepted op finishes 33 edges later; a busy unit ignores start.
  always @(posedge clock) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dbz  = p_dbz;
        end
      end else if (start) begin
        if (md_Control <= 3'b011) begin
          modelOp(md_Control, src_A, src_B, p_hi, p_lo, p_dbz);
          m_cnt  = 33;
          m_busy = 1'b1;
          m_dbz  = 1'b0;
        end else if (md_Control == 3'b100) begin
          m_hi = src_A;
        end else if (md_Control == 3'b101) begin
          m_lo = src_A;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
      checkOutput("done", {31'b0, done}, {31'b0, m_done});
      checkOutput("div_By_Zero", {31'b0, div_By_Zero}, {31'b0, m_dbz});
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
    end
  end

  // Issues a one-cycle start pulse.
  // It is entered #1 after an edge and returns #1 after the sampling edge E0.
  task automatic applyStimulus(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    md_Control = code;
    src_A      = a;
    src_B      = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done.
  // It checks the latency from E0 and the final HI/LO/div_By_Zero against literals.
  task automatic waitResult(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_dbz);
    int edges;
    edges = 0;
    do begin
      @(posedge clock);
      #1;
      edges++;
    end while (!done && edges < 40);
    checkOutput({name, " latency"}, 32'(edges), 32'd33);
    checkOutput({name, " hi"}, hi, exp_hi);
    checkOutput({name, " lo"}, lo, exp_lo);
    checkOutput({name, " dbz"}, {31'b0, div_By_Zero}, {31'b0, exp_dbz});
  endtask

  task automatic runOp(input string name, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_dbz);
    applyStimulus(code, a, b);
    checkOutput({name, " busy at E0"}, {31'b0, busy}, 32'd1);
    waitResult(name, exp_hi, exp_lo, exp_dbz);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] h;
    logic [31:0] l;
    bit          d;

    reset      = 1'b0;
    start      = 1'b0;
    md_Control = 3'b000;
    src_A      = '0;
    src_B      = '0;

    // Pin the reference model with hand-computed values.
    modelOp(3'b000, 32'd7, 32'd6, h, l, d);
    checkOutput("model mult hi", h, 32'd0);
    checkOutput("model mult lo", l, 32'd42);
    modelOp(3'b010, 32'hFFFF_FFF9, 32'd2, h, l, d);
    checkOutput("model div hi", h, 32'hFFFF_FFFF);
    checkOutput("model div lo", l, 32'hFFFF_FFFD);
    modelOp(3'b011, 32'd5, 32'd0, h, l, d);
    checkOutput("model dbz hi", h, 32'd5);
    checkOutput("model dbz flag", {31'b0, d}, 32'd1);

    @(posedge clock);
    #1;
    check_en = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    runOp("mult 7*6", 3'b000, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("done one cycle", {31'b0, done}, 32'd0);

    runOp("mult -3*5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    // Back-to-back: this start is sampled on the edge where done is still high.
    runOp("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("divu 100/7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runOp("div min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    runOp("divu 5/0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'b000, 32'd3, 32'd4);
    checkOutput("dbz cleared by start", {31'b0, div_By_Zero}, 32'd0);
    waitResult("mult 3*4", 32'd0, 32'd12, 1'b0);
    runOp("div -7/0", 3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // A start pulse and operand change at E10 of a running MULT are ignored.
    applyStimulus(3'b000, 32'd1000, 32'd1000);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      #1;
    end
    start      = 1'b1;
    md_Control = 3'b011;
    src_A      = 32'd9;
    src_B      = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    src_A = 32'hDEAD_BEEF;
    h = 32'd0;
    for (int i = 11; i <= 40 && !done; i++) begin
      @(posedge clock);
      #1;
      h = 32'(i);
    end
    checkOutput("ignored start latency", h, 32'd33);
    checkOutput("ignored start lo", lo, 32'd1000000);
    checkOutput("ignored start hi", hi, 32'd0);
    @(posedge clock);
    #1;

    // MTHI, MTLO and the unused codes 110/111.
    applyStimulus(3'b100, 32'd1234, 32'd0);
    checkOutput("mthi hi", hi, 32'd1234);
    checkOutput("mthi done", {31'b0, done}, 32'd0);
    checkOutput("mthi busy", {31'b0, busy}, 32'd0);
    applyStimulus(3'b101, 32'd55, 32'd0);
    checkOutput("mtlo lo", lo, 32'd55);
    checkOutput("mtlo hi kept", hi, 32'd1234);
    applyStimulus(3'b110, 32'd77, 32'd0);
    checkOutput("code110 hi", hi, 32'd1234);
    checkOutput("code110 lo", lo, 32'd55);
    applyStimulus(3'b111, 32'd88, 32'd0);
    checkOutput("code111 busy", {31'b0, busy}, 32'd0);
    checkOutput("code111 lo", lo, 32'd55);

    // A reset at E15 of a DIV aborts it; a new start at E17 completes at E50.
    applyStimulus(3'b010, 32'd100, 32'd3);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    runOp("div 100/-3", 3'b010, 32'd100, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFDF, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("final done low", {31'b0, done}, 32'd0);

    @(negedge clock);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
